// File: rtl/log_uart_drain.sv
// Drains 32-bit words from the logger FIFO and sends each one over an 8N1 UART,
// most significant byte first. The next word is popped only after the last stop bit.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle (tx=1); pop when enabled and the FIFO has data
// S_POP   | one-cycle fifo_rd_en strobe
// S_WAIT  | FIFO read data valid; latch the word, select byte 0
// S_START | start bit (tx=0) for CLKS_PER_BIT cycles
// S_DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// S_STOP  | stop bit (tx=1); next byte, or count the word and go idle
module log_uart_drain #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_data,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic [15:0] words_sent
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_nxt;
    logic [15:0] baud_q, baud_nxt;
    logic [2:0]  bit_q, bit_nxt;
    logic [1:0]  byte_q, byte_nxt;
    logic [31:0] word_q, word_nxt;
    logic [15:0] sent_q, sent_nxt;
    logic        tx_q, tx_nxt;
    logic        rd_en_q, rd_en_nxt;
    logic        busy_q, busy_nxt;
    logic        baud_done;
    logic [7:0]  byte_cur;

    assign baud_done  = (baud_q == BAUD_LAST);
    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign words_sent = sent_q;

    // Next state, counters and word register; the baud counter restarts on every transition.
    always_comb begin
        state_nxt = state_q;
        baud_nxt  = baud_q + 16'd1;
        bit_nxt   = bit_q;
        byte_nxt  = byte_q;
        word_nxt  = word_q;
        sent_nxt  = sent_q;
        case (state_q)
            S_IDLE: begin
                baud_nxt = 16'd0;
                if (enable && !fifo_empty) begin
                    state_nxt = S_POP;
                end
            end
            S_POP: begin
                baud_nxt  = 16'd0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                baud_nxt  = 16'd0;
                word_nxt  = fifo_data;
                byte_nxt  = 2'd0;
                state_nxt = S_START;
            end
            S_START: begin
                if (baud_done) begin
                    baud_nxt  = 16'd0;
                    bit_nxt   = 3'd0;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_nxt = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        bit_nxt = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_nxt = 16'd0;
                    if (byte_q == 2'd3) begin
                        sent_nxt  = sent_q + 16'd1;
                        state_nxt = S_IDLE;
                    end else begin
                        byte_nxt  = byte_q + 2'd1;
                        state_nxt = S_START;
                    end
                end
            end
            default: begin
                baud_nxt  = 16'd0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Byte about to be on the line, picked from the next-cycle word and byte index.
    always_comb begin
        byte_cur = word_nxt[31:24];
        case (byte_nxt)
            2'd0: byte_cur = word_nxt[31:24];
            2'd1: byte_cur = word_nxt[23:16];
            2'd2: byte_cur = word_nxt[15:8];
            2'd3: byte_cur = word_nxt[7:0];
            default: byte_cur = word_nxt[31:24];
        endcase
    end

    // Registered outputs are derived from the next state so they line up with the state register.
    always_comb begin
        tx_nxt    = 1'b1;
        rd_en_nxt = (state_nxt == S_POP);
        busy_nxt  = (state_nxt != S_IDLE);
        case (state_nxt)
            S_START: tx_nxt = 1'b0;
            S_DATA:  tx_nxt = byte_cur[bit_nxt];
            default: tx_nxt = 1'b1;
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            word_q  <= 32'd0;
            sent_q  <= 16'd0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            baud_q  <= baud_nxt;
            bit_q   <= bit_nxt;
            byte_q  <= byte_nxt;
            word_q  <= word_nxt;
            sent_q  <= sent_nxt;
            tx_q    <= tx_nxt;
            rd_en_q <= rd_en_nxt;
            busy_q  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_log_uart_drain.sv
// Bench for log_uart_drain: a FIFO model feeds words, a UART receiver model
// reassembles them and compares against the order the FIFO handed them out.
module tb_log_uart_drain;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = 32'd0;
    logic        fifo_rd_en;
    logic        tx;
    logic        busy;
    logic [15:0] words_sent;

    log_uart_drain #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    int          pop_times[$];
    int          frame_starts[$];
    logic [9:0]  frame_log[$];
    logic        hide = 1'b0;
    int          cyc = 0;
    int          busy_cyc = 0;
    int          words_done = 0;
    logic [31:0] last_word = 32'd0;

    int          rd_run = 0;
    int          mon_pos = -1;
    int          nbytes = 0;
    int          kbit;
    logic [9:0]  fbits = 10'd0;
    logic [31:0] mon_word = 32'd0;
    logic        prev_tx = 1'b1;

    always @(posedge clk) cyc++;

    // FIFO model plus UART receiver model, both evaluated mid-cycle.
    always @(negedge clk) begin
        if (fifo_rd_en) begin
            pop_times.push_back(cyc);
            chk("pop_nonempty", 32'(fifo_q.size() > 0), 32'd1);
            if (fifo_q.size() > 0) begin
                fifo_data = fifo_q.pop_front();
                exp_q.push_back(fifo_data);
            end
            rd_run++;
        end else if (rd_run != 0) begin
            chk("rd_en_width", 32'(rd_run), 32'd1);
            rd_run = 0;
        end
        fifo_empty = (fifo_q.size() == 0) || hide;
        if (busy) busy_cyc++;
        if (!reset) begin
            mon_pos = -1;
            nbytes  = 0;
            exp_q.delete();
            prev_tx = 1'b1;
        end else begin
            if (mon_pos < 0) begin
                if (prev_tx && !tx) begin
                    mon_pos = 0;
                    frame_starts.push_back(cyc);
                end
            end else begin
                mon_pos++;
            end
            if (mon_pos >= 0 && (mon_pos % CPB) == CPB / 2) begin
                kbit = mon_pos / CPB;
                fbits[kbit] = tx;
                if (kbit == 9) begin
                    chk("start_bit", 32'(fbits[0]), 32'd0);
                    chk("stop_bit", 32'(fbits[9]), 32'd1);
                    frame_log.push_back(fbits);
                    mon_word = {mon_word[23:0], fbits[8:1]};
                    nbytes++;
                    mon_pos = -1;
                    if (nbytes == 4) begin
                        nbytes = 0;
                        words_done++;
                        last_word = mon_word;
                        chk("word_queued", 32'(exp_q.size() > 0), 32'd1);
                        if (exp_q.size() > 0) chk("word_data", mon_word, exp_q.pop_front());
                    end
                end
            end
            prev_tx = tx;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int t = 0;
        while (frame_starts.size() < n && t < budget) begin step(); t++; end
        if (frame_starts.size() < n) chk(tag, 32'(frame_starts.size()), 32'(n));
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int t = 0;
        while (words_done < n && t < budget) begin step(); t++; end
        if (words_done < n) chk(tag, 32'(words_done), 32'(n));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t = 0;
        while (busy && t < budget) begin step(); t++; end
        chk(tag, 32'(busy), 32'd0);
    endtask

    localparam int WORD_CYC = 40 * CPB;

    initial begin
        int fs0, p0, b0, w0, n_rand, lows, busies, pops;
        logic [31:0] w, y;

        // Reset state
        steps(2);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_words", 32'(words_sent), 32'd0);
        reset = 1'b1;
        steps(2);

        // Single word: timing, serial pattern, busy length
        fs0 = frame_starts.size(); p0 = pop_times.size(); b0 = busy_cyc; w0 = words_done;
        fifo_q.push_back(32'hA5C3_0F81);
        enable = 1'b1;
        wait_words("t1_timeout", w0 + 1, 400);
        wait_idle("t1_idle", 50);
        chk("t1_pop_to_start", 32'(frame_starts[fs0] - pop_times[p0]), 32'd2);
        chk("t1_a5_frame", 32'(frame_log[fs0]), 32'(10'b1101001010));
        chk("t1_byte1", 32'(frame_log[fs0 + 1][8:1]), 32'h0C3);
        chk("t1_byte2", 32'(frame_log[fs0 + 2][8:1]), 32'h00F);
        chk("t1_byte3", 32'(frame_log[fs0 + 3][8:1]), 32'h081);
        chk("t1_byte_spacing", 32'(frame_starts[fs0 + 3] - frame_starts[fs0 + 2]), 32'(10 * CPB));
        chk("t1_busy_len", 32'(busy_cyc - b0), 32'(WORD_CYC + 2));
        chk("t1_words", 32'(words_sent), 32'd1);

        // Two back-to-back words
        fs0 = frame_starts.size(); p0 = pop_times.size(); w0 = words_done;
        fifo_q.push_back(32'h0000_0000);
        fifo_q.push_back(32'hFFFF_FFFF);
        wait_words("t2_timeout", w0 + 2, 800);
        wait_idle("t2_idle", 50);
        chk("t2_pop_gap", 32'(pop_times[p0 + 1] - pop_times[p0]), 32'(WORD_CYC + 3));
        chk("t2_word_gap", 32'(frame_starts[fs0 + 4] - frame_starts[fs0 + 3]), 32'(10 * CPB + 3));
        chk("t2_words", 32'(words_sent), 32'd3);

        // Random words
        w0 = words_done; p0 = pop_times.size();
        n_rand = 8;
        for (int i = 0; i < n_rand; i++) fifo_q.push_back($urandom);
        wait_words("t3_timeout", w0 + n_rand, n_rand * 200 + 100);
        wait_idle("t3_idle", 50);
        chk("t3_pops", 32'(pop_times.size() - p0), 32'(n_rand));
        chk("t3_words", 32'(words_sent), 32'(3 + n_rand));

        // enable low blocks pops; dropping it mid-word only blocks the next pop
        enable = 1'b0;
        p0 = pop_times.size();
        fifo_q.push_back($urandom);
        lows = 0; busies = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!tx) lows++;
            if (busy) busies++;
        end
        chk("t4_no_pop", 32'(pop_times.size() - p0), 32'd0);
        chk("t4_tx_low_cycles", 32'(lows), 32'd0);
        chk("t4_busy_cycles", 32'(busies), 32'd0);
        fifo_q.push_back($urandom);
        fs0 = frame_starts.size(); w0 = words_done;
        enable = 1'b1;
        wait_frames("t4_start_timeout", fs0 + 2, 200);
        steps(10);
        enable = 1'b0;
        wait_words("t4_timeout", w0 + 1, 400);
        steps(100);
        chk("t4_single_pop", 32'(pop_times.size() - p0), 32'd1);
        chk("t4_left_in_fifo", 32'(fifo_q.size()), 32'd1);
        chk("t4_busy_after", 32'(busy), 32'd0);
        enable = 1'b1;
        wait_words("t4b_timeout", w0 + 2, 400);
        wait_idle("t4b_idle", 50);
        chk("t4_words", 32'(words_sent), 32'(5 + n_rand));

        // Reset during data bits of byte 2
        y = 32'h3C5A_96E1;
        fs0 = frame_starts.size(); w0 = words_done;
        fifo_q.push_back(32'h1234_5678);
        fifo_q.push_back(y);
        wait_frames("t5_start_timeout", fs0 + 2, 300);
        steps(14);
        reset = 1'b0;
        #1;
        chk("t5_rst_tx", 32'(tx), 32'd1);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_words", 32'(words_sent), 32'd0);
        chk("t5_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        steps(3);
        reset = 1'b1;
        wait_words("t5_timeout", w0 + 1, 400);
        wait_idle("t5_idle", 50);
        chk("t5_fresh_word", last_word, y);
        chk("t5_words", 32'(words_sent), 32'd1);

        // words_sent wrap
        force dut.sent_q = 16'hFFFF;
        #1;
        release dut.sent_q;
        step();
        chk("t6_preset", 32'(words_sent), 32'h0000_FFFF);
        w0 = words_done;
        fifo_q.push_back($urandom);
        wait_words("t6_timeout", w0 + 1, 400);
        wait_idle("t6_idle", 50);
        chk("t6_wrap", 32'(words_sent), 32'd0);

        // fifo_empty glitch during the last stop bit must not change popping
        fs0 = frame_starts.size(); p0 = pop_times.size(); w0 = words_done;
        fifo_q.push_back($urandom);
        fifo_q.push_back($urandom);
        wait_frames("t7_start_timeout", fs0 + 4, 400);
        steps(36);
        hide = 1'b1;
        step();
        hide = 1'b0;
        wait_words("t7_timeout", w0 + 2, 800);
        wait_idle("t7_idle", 50);
        steps(20);
        pops = pop_times.size() - p0;
        chk("t7_pops", 32'(pops), 32'd2);
        if (pops == 2) chk("t7_pop_gap", 32'(pop_times[p0 + 1] - pop_times[p0]), 32'(WORD_CYC + 3));
        chk("t7_words", 32'(words_sent), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
